// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-back, write-allocate data cache with
// a built-in miss controller (IDLE -> [WB] -> FILL -> IDLE).
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cpu_req/we/addr/wdata   CPU access; the CPU holds it until cpu_ready
//   cpu_rdata, cpu_ready    read data / same-cycle hit completion
//   mem_req/we/addr/wdata   one word per request toward main memory
//   mem_rdata, mem_ack      fill data / word-transferred strobe
//   miss_count              misses detected (saturating)
//   access_count            completed accesses (saturating)
module dm_cache_ctrl #(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 16,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] access_count
);

    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(NUM_LINES);
    localparam int TW = 32 - WB - IB - 2;

    typedef enum logic [1:0] {IDLE, WBACK, FILL} state_t;

    state_t                 state_q, state_d;
    logic [WB-1:0]          cnt_q, cnt_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [NUM_LINES-1:0]   dirty_q, dirty_d;
    logic [CNT_W-1:0]       miss_q, miss_d;
    logic [CNT_W-1:0]       acc_q, acc_d;

    // Tag and data storage carry no reset; valid_q alone qualifies them.
    logic [TW-1:0]          tag_q  [NUM_LINES];
    logic [31:0]            data_q [NUM_LINES][WORDS_PER_LINE];

    logic [WB-1:0]          a_word;
    logic [IB-1:0]          a_idx;
    logic [TW-1:0]          a_tag;
    logic                   hit;
    logic                   last;
    logic                   miss_inc;
    logic                   data_we;
    logic [WB-1:0]          data_wword;
    logic [31:0]            data_wdata;
    logic                   tag_we;

    assign a_word = cpu_addr[WB+1:2];
    assign a_idx  = cpu_addr[WB+IB+1:WB+2];
    assign a_tag  = cpu_addr[31:WB+IB+2];
    assign hit    = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
    assign last   = (cnt_q == WB'(WORDS_PER_LINE - 1));

    assign cpu_rdata    = data_q[a_idx][a_word];
    assign miss_count   = miss_q;
    assign access_count = acc_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        miss_inc   = 1'b0;
        cpu_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        data_we    = 1'b0;
        data_wword = a_word;
        data_wdata = cpu_wdata;
        tag_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req && hit) begin
                    cpu_ready = 1'b1;
                    if (cpu_we) begin
                        data_we        = 1'b1;
                        dirty_d[a_idx] = 1'b1;
                    end
                end else if (cpu_req) begin
                    miss_inc = 1'b1;
                    cnt_d    = '0;
                    state_d  = (valid_q[a_idx] && dirty_q[a_idx]) ? WBACK : FILL;
                end
            end
            WBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[a_idx], a_idx, cnt_q, 2'b00};
                mem_wdata = data_q[a_idx][cnt_q];
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        cnt_d          = '0;
                        dirty_d[a_idx] = 1'b0;
                        state_d        = FILL;
                    end
                end
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {a_tag, a_idx, cnt_q, 2'b00};
                if (mem_ack) begin
                    data_we    = 1'b1;
                    data_wword = cnt_q;
                    data_wdata = mem_rdata;
                    cnt_d      = cnt_q + 1'b1;
                    // Line becomes visible only once the final word is in.
                    if (last) begin
                        valid_d[a_idx] = 1'b1;
                        dirty_d[a_idx] = 1'b0;
                        tag_we         = 1'b1;
                        state_d        = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset forces the bus and CPU handshake quiet even while state_q is stale.
        if (reset) begin
            cpu_ready = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            data_we   = 1'b0;
            tag_we    = 1'b0;
        end
        miss_d = miss_q + CNT_W'(miss_inc && (miss_q != '1));
        acc_d  = acc_q + CNT_W'(cpu_ready && (acc_q != '1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            miss_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            miss_q  <= miss_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_q[a_idx][data_wword] <= data_wdata;
        if (tag_we)  tag_q[a_idx] <= a_tag;
    end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Parametrised direct-mapped, write-back, write-allocate data cache with its own miss-handling controller.
- Sits between the CPU data port and word-wide main memory.
- Holds NUM_LINES lines of WORDS_PER_LINE 32-bit words each, with per-line valid, dirty and tag.
- On a miss it writes back a dirty victim, then fills the line one word per memory acknowledge, and stalls the CPU throughout.

Parameters:
- NUM_LINES, 8, number of lines; power of two, ≥2.
- WORDS_PER_LINE, 16, 32-bit words per line; power of two, ≥2.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address; bits [1:0] ignored
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  read data, valid when cpu_ready=1 and cpu_we=0
- cpu_ready  out  1  access completes this cycle
- mem_req  out  1  memory word request
- mem_we  out  1  1 = write-back word, 0 = fill read
- mem_addr  out  32  word-aligned memory address
- mem_wdata  out  32  write-back data
- mem_rdata  in  32  fill data, valid with mem_ack
- mem_ack  in  1  one word transferred this cycle
- miss_count  out  CNT_W  misses detected, saturating
- access_count  out  CNT_W  completed accesses, saturating

Behaviour:
- Reset is synchronous, active-high, on clk.
  - Clears all valid and dirty bits, FSM to IDLE, word counter to 0, both counters to 0.
  - Outputs during/after reset: mem_req=0, mem_we=0, cpu_ready=0.
  - Tag and data arrays are not reset.
- Address split, with WB = log2(WORDS_PER_LINE) and IB = log2(NUM_LINES):
  - word = addr[WB+1:2]
  - index = addr[WB+IB+1:WB+2]
  - tag = addr[31:WB+IB+2]
- hit = valid[index] && tag_array[index] == tag (combinational).
- cpu_rdata = data[index][word] (combinational).
- cpu_ready = (state==IDLE) && cpu_req && hit. Zero-wait hit: completes in the same cycle.
- Write hit: data[index][word] <= cpu_wdata and dirty[index] <= 1 at the posedge where cpu_ready=1. No memory traffic.
- CPU must hold cpu_req, cpu_we, cpu_addr and cpu_wdata stable while cpu_ready=0. The controller does not latch the request.
- State IDLE:
  - cpu_req && !hit:
    - miss_count increments.
    - If valid && dirty: go to WB, counter=0.
    - Else: go to FILL, counter=0.
  - No request or hit: stay in IDLE.
- State WB:
  - mem_req=1, mem_we=1.
  - mem_addr = {victim tag, index, counter, 2'b00}; mem_wdata = data[index][counter].
  - Each mem_ack increments counter.
  - Ack with counter==WORDS_PER_LINE-1: go to FILL, counter=0, dirty[index] <= 0.
- State FILL:
  - mem_req=1, mem_we=0.
  - mem_addr = {cpu tag, index, counter, 2'b00}.
  - On mem_ack: data[index][counter] <= mem_rdata, counter increments.
  - Last ack: valid <= 1, tag <= cpu tag, dirty <= 0, go to IDLE.
  - The held request then hits on the next cycle.
- mem_addr and mem_wdata stay constant between acks; ack gaps of any length are allowed.
- mem_ack outside WB/FILL is ignored.
- Latency:
  - Clean miss: WORDS_PER_LINE ack cycles + 1 cycle to cpu_ready.
  - Dirty miss: 2×WORDS_PER_LINE ack cycles + 1 cycle.
- Fill order is always word 0 upward; there is no critical-word-first.
- The valid bit is set only after the last fill word. A partially filled line never hits.
- Reset mid-WB or mid-FILL aborts immediately.
  - mem_req is 0 on the cycle after reset.
  - The line is invalid after reset because all valid bits are cleared.
- access_count increments on every cycle with cpu_ready=1. A missed access counts once in each counter.
- Both counters hold at all-ones.
- Same-cycle hit write and counter update are independent; no hazards exist because only one access is outstanding.

Test Plan (NUM_LINES=8, WORDS_PER_LINE=16: word=[5:2], index=[8:6], tag=[31:9]):
1. After reset, read 0x0000_0040, memory acks each word with data 0x1000+i.
   - mem_we=0, mem_addr steps 0x40, 0x44 … 0x7C.
   - After 16 acks plus 1 cycle: cpu_ready=1, cpu_rdata=0x0000_1000.
   - miss_count=1, access_count=1.
2. Write 0x48 data 0xDEADBEEF, then read 0x48.
   - Both accesses complete with cpu_ready=1 in their first cycle, with no mem_req.
   - The read returns 0xDEADBEEF; access_count=3.
3. Read 0x0000_0240 (same index, different tag).
   - Write-back: 16 words to 0x40..0x7C, word 2 = 0xDEADBEEF, others 0x1000+i.
   - Then fill from 0x240..0x27C; read returns the fill word 0.
4. Read 0x0000_0440 (line now clean).
   - No write-back; the first mem_req cycle has mem_we=0 and mem_addr=0x440.
5. Read 0x0000_0080, assert reset for 1 cycle after 5 fill acks.
   - mem_req=0 next cycle; both counters read 0.
   - Re-reading 0x80 misses again and performs a full 16-word fill.
6. Fill with random 0–3-cycle gaps between mem_ack pulses.
   - mem_addr is stable across gaps; all 16 words land correctly.
   - Preload counters near saturation: they stop at 0xFFFF.
